// File: rtl/hzd_pkg.sv
// rtl/hzd_pkg.sv - shared defaults, stage record and mode encoding for the hazard controller
package hzd_pkg;

    localparam int ADDR_W_DEF      = 4;
    localparam int NUM_SRC_DEF     = 2;
    localparam int BYP_STAGES_DEF  = 2;
    localparam int MUL_LAT_DEF     = 3;
    localparam int FLUSH_DEPTH_DEF = 2;

    localparam int CNT_W      = 4;
    localparam int MAX_ADDR_W = 8;

    // dst is stored zero-extended so one record type serves any ADDR_W up to MAX_ADDR_W
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [MAX_ADDR_W-1:0] dst;
        logic                  is_load;
    } stage_t;

    typedef enum logic [2:0] {
        MODE_RUN,
        MODE_FLUSH,
        MODE_MUL,
        MODE_LOAD_USE,
        MODE_HALT
    } hzd_mode_t;

endpackage

// File: rtl/hzd_if.sv
// rtl/hzd_if.sv - ID-stage request and hazard response bundle
interface hzd_if
    import hzd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int BYP_STAGES = BYP_STAGES_DEF
);
    logic                          id_valid;
    logic [NUM_SRC*ADDR_W-1:0]     id_src_addr;
    logic [NUM_SRC-1:0]            id_src_re;
    logic [ADDR_W-1:0]             id_dst_addr;
    logic                          id_rf_we;
    logic                          id_is_load;
    logic                          id_is_mul;
    logic                          id_is_hlt;
    logic                          flow_change;
    logic                          stall_if;
    logic                          bubble_id;
    logic [NUM_SRC*BYP_STAGES-1:0] byp_sel;
    logic                          mul_busy;
    logic                          hlt_done;

    modport master (
        output id_valid, id_src_addr, id_src_re, id_dst_addr, id_rf_we,
               id_is_load, id_is_mul, id_is_hlt, flow_change,
        input  stall_if, bubble_id, byp_sel, mul_busy, hlt_done
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_re, id_dst_addr, id_rf_we,
               id_is_load, id_is_mul, id_is_hlt, flow_change,
        output stall_if, bubble_id, byp_sel, mul_busy, hlt_done
    );

endinterface

// File: rtl/hzd_byp_match.sv
// rtl/hzd_byp_match.sv - one source port against all in-flight stages, youngest match wins
module hzd_byp_match
    import hzd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BYP_STAGES = BYP_STAGES_DEF
) (
    input  logic [ADDR_W-1:0]           src_addr,
    input  logic                        src_re,
    input  stage_t [BYP_STAGES-1:0]     stages,
    output logic [BYP_STAGES-1:0]       sel,
    output logic                        src_ld
);
    logic [BYP_STAGES-1:0] hit;

    always_comb begin
        hit    = '0;
        sel    = '0;
        src_ld = 1'b0;
        for (int s = 0; s < BYP_STAGES; s++) begin
            hit[s] = src_re & stages[s].valid & stages[s].we &
                     (stages[s].dst == MAX_ADDR_W'(src_addr)) & (src_addr != '0);
        end
        // scan oldest to youngest so the youngest hit overwrites
        for (int s = BYP_STAGES - 1; s >= 0; s--) begin
            if (hit[s]) begin
                sel    = '0;
                sel[s] = 1'b1;
                src_ld = stages[s].is_load;
            end
        end
    end

endmodule

// File: rtl/hzd_ctrl.sv
// rtl/hzd_ctrl.sv - pipeline hazard controller: forwarding select, load-use, multiply, flush and halt
module hzd_ctrl
    import hzd_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int BYP_STAGES  = BYP_STAGES_DEF,
    parameter int MUL_LAT     = MUL_LAT_DEF,
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
    input  logic  clk,
    input  logic  rst,
    hzd_if.slave  bus
);
    stage_t [BYP_STAGES-1:0]       entries, entries_d;
    logic [CNT_W-1:0]              mul_cnt, mul_cnt_d, flush_cnt, flush_cnt_d;
    logic                          hlt_pending, hlt_pending_d, hlt_done_q, hlt_done_d;
    logic [NUM_SRC*BYP_STAGES-1:0] byp_sel_q, byp_sel_d, match_sel;
    logic [NUM_SRC-1:0]            ld_hit;
    logic                          flush_act, mul_act, load_use, all_idle, accept;
    hzd_mode_t                     mode;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [BYP_STAGES-1:0] sel;
        logic                  src_ld;

        hzd_byp_match #(
            .ADDR_W     (ADDR_W),
            .BYP_STAGES (BYP_STAGES)
        ) u_match (
            .src_addr (bus.id_src_addr[k*ADDR_W +: ADDR_W]),
            .src_re   (bus.id_src_re[k]),
            .stages   (entries),
            .sel      (sel),
            .src_ld   (src_ld)
        );

        assign match_sel[k*BYP_STAGES +: BYP_STAGES] = sel;
        assign ld_hit[k] = sel[0] & src_ld;
    end

    always_comb begin
        flush_act = bus.flow_change | (flush_cnt != '0);
        mul_act   = (mul_cnt != '0);
        load_use  = bus.id_valid & (|ld_hit);
        all_idle  = 1'b1;
        for (int s = 0; s < BYP_STAGES; s++) begin
            if (entries[s].valid) all_idle = 1'b0;
        end
        if (rst)              mode = MODE_RUN;
        else if (flush_act)   mode = MODE_FLUSH;
        else if (mul_act)     mode = MODE_MUL;
        else if (load_use)    mode = MODE_LOAD_USE;
        else if (hlt_pending) mode = MODE_HALT;
        else                  mode = MODE_RUN;
    end

    always_comb begin
        accept    = (mode == MODE_RUN) & bus.id_valid;
        entries_d = entries;
        if (!mul_act) begin
            entries_d[0].valid   = accept;
            entries_d[0].we      = bus.id_rf_we;
            entries_d[0].dst     = MAX_ADDR_W'(bus.id_dst_addr);
            entries_d[0].is_load = bus.id_is_load;
        end
        // a frozen EX hands a bubble to DM; everything older keeps draining
        for (int s = 1; s < BYP_STAGES; s++) begin
            entries_d[s] = (mul_act && s == 1) ? '0 : entries[s-1];
        end

        if (accept && bus.id_is_mul) mul_cnt_d = CNT_W'(MUL_LAT - 1);
        else if (mul_act)            mul_cnt_d = mul_cnt - CNT_W'(1);
        else                         mul_cnt_d = mul_cnt;

        if (bus.flow_change)         flush_cnt_d = CNT_W'(FLUSH_DEPTH - 1);
        else if (flush_cnt != '0)    flush_cnt_d = flush_cnt - CNT_W'(1);
        else                         flush_cnt_d = flush_cnt;

        hlt_pending_d = hlt_pending | (accept & bus.id_is_hlt);
        hlt_done_d    = hlt_done_q | (hlt_pending & all_idle & ~mul_act);

        // kept free of flow_change so the select register has no path from branch resolve
        if (mul_act)                                    byp_sel_d = byp_sel_q;
        else if (load_use || hlt_pending || !bus.id_valid) byp_sel_d = '0;
        else                                            byp_sel_d = match_sel;
    end

    always_comb begin
        bus.stall_if  = mode inside {MODE_MUL, MODE_LOAD_USE, MODE_HALT};
        bus.bubble_id = mode inside {MODE_FLUSH, MODE_LOAD_USE, MODE_HALT};
        bus.mul_busy  = mul_act & ~rst;
        bus.hlt_done  = hlt_done_d & ~rst;
        bus.byp_sel   = byp_sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries     <= '0;
            mul_cnt     <= '0;
            flush_cnt   <= '0;
            hlt_pending <= 1'b0;
            hlt_done_q  <= 1'b0;
            byp_sel_q   <= '0;
        end else begin
            entries     <= entries_d;
            mul_cnt     <= mul_cnt_d;
            flush_cnt   <= flush_cnt_d;
            hlt_pending <= hlt_pending_d;
            hlt_done_q  <= hlt_done_d;
            byp_sel_q   <= byp_sel_d;
        end
    end

endmodule

// File: tb/tb_hzd_ctrl.sv
// tb/tb_hzd_ctrl.sv - directed self-checking bench for hzd_ctrl
module tb_hzd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    hzd_if #(.ADDR_W(4), .NUM_SRC(2), .BYP_STAGES(2)) bus ();

    hzd_ctrl #(
        .ADDR_W(4), .NUM_SRC(2), .BYP_STAGES(2), .MUL_LAT(3), .FLUSH_DEPTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s0, input logic r0,
                         input logic [3:0] s1, input logic r1, input logic [3:0] d,
                         input logic we, input logic ld, input logic mul, input logic hlt);
        bus.id_valid    = v;
        bus.id_src_addr = {s1, s0};
        bus.id_src_re   = {r1, r0};
        bus.id_dst_addr = d;
        bus.id_rf_we    = we;
        bus.id_is_load  = ld;
        bus.id_is_mul   = mul;
        bus.id_is_hlt   = hlt;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.flow_change = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        #1;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL rst_stall got=%0b exp=0", bus.stall_if); else n_pass++;
        n_chk++; if (bus.bubble_id !== 1'b0) $display("FAIL rst_bubble got=%0b exp=0", bus.bubble_id); else n_pass++;
        n_chk++; if (bus.mul_busy !== 1'b0) $display("FAIL rst_mul got=%0b exp=0", bus.mul_busy); else n_pass++;
        n_chk++; if (bus.hlt_done !== 1'b0) $display("FAIL rst_hlt got=%0b exp=0", bus.hlt_done); else n_pass++;
        n_chk++; if (bus.byp_sel !== 4'b0000) $display("FAIL rst_byp got=%b exp=0000", bus.byp_sel); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        tick(); drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); #1;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL add_stall got=%0b exp=0", bus.stall_if); else n_pass++;
        tick(); drive(1, 0, 0, 3, 1, 4, 1, 0, 0, 0);
        tick(); idle(); #1;
        n_chk++; if (bus.byp_sel !== 4'b0100) $display("FAIL fwd_ex_p1 got=%b exp=0100", bus.byp_sel); else n_pass++;
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        tick(); idle(); #1;
        n_chk++; if (bus.byp_sel !== 4'b0000) $display("FAIL fwd_r0 got=%b exp=0000", bus.byp_sel); else n_pass++;
        tick(); drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        tick(); drive(1, 6, 1, 0, 0, 7, 1, 0, 0, 0);
        tick(); idle(); #1;
        n_chk++; if (bus.byp_sel !== 4'b0001) $display("FAIL fwd_youngest got=%b exp=0001", bus.byp_sel); else n_pass++;
        tick(); drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        tick(); idle();
        tick(); drive(1, 9, 1, 9, 1, 10, 1, 0, 0, 0);
        tick(); idle(); #1;
        n_chk++; if (bus.byp_sel !== 4'b1010) $display("FAIL fwd_dm_both got=%b exp=1010", bus.byp_sel); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_load_use();
        tick(); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick(); drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0); #1;
        n_chk++; if (bus.stall_if !== 1'b1) $display("FAIL lu_stall got=%0b exp=1", bus.stall_if); else n_pass++;
        n_chk++; if (bus.bubble_id !== 1'b1) $display("FAIL lu_bubble got=%0b exp=1", bus.bubble_id); else n_pass++;
        tick(); #1;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL lu_release got=%0b exp=0", bus.stall_if); else n_pass++;
        n_chk++; if (bus.byp_sel !== 4'b0000) $display("FAIL lu_byp_bubble got=%b exp=0000", bus.byp_sel); else n_pass++;
        tick(); idle(); #1;
        n_chk++; if (bus.byp_sel !== 4'b0010) $display("FAIL lu_byp_dm got=%b exp=0010", bus.byp_sel); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_mul();
        tick(); drive(1, 0, 0, 0, 0, 2, 1, 0, 1, 0); #1;
        n_chk++; if (bus.mul_busy !== 1'b0) $display("FAIL mul_accept_busy got=%0b exp=0", bus.mul_busy); else n_pass++;
        tick(); drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0); #1;
        n_chk++; if (bus.mul_busy !== 1'b1) $display("FAIL mul_busy1 got=%0b exp=1", bus.mul_busy); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b1) $display("FAIL mul_stall1 got=%0b exp=1", bus.stall_if); else n_pass++;
        n_chk++; if (bus.bubble_id !== 1'b0) $display("FAIL mul_bubble1 got=%0b exp=0", bus.bubble_id); else n_pass++;
        tick(); #1;
        n_chk++; if (bus.mul_busy !== 1'b1) $display("FAIL mul_busy2 got=%0b exp=1", bus.mul_busy); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b1) $display("FAIL mul_stall2 got=%0b exp=1", bus.stall_if); else n_pass++;
        tick(); #1;
        n_chk++; if (bus.mul_busy !== 1'b0) $display("FAIL mul_done got=%0b exp=0", bus.mul_busy); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL mul_stall_end got=%0b exp=0", bus.stall_if); else n_pass++;
        tick(); idle(); tick();
    endtask

    task automatic test_flush();
        tick(); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick(); drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0); bus.flow_change = 1'b1; #1;
        n_chk++; if (bus.bubble_id !== 1'b1) $display("FAIL fl_bubble1 got=%0b exp=1", bus.bubble_id); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL fl_stall1 got=%0b exp=0", bus.stall_if); else n_pass++;
        tick(); bus.flow_change = 1'b0; #1;
        n_chk++; if (bus.bubble_id !== 1'b1) $display("FAIL fl_bubble2 got=%0b exp=1", bus.bubble_id); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL fl_stall2 got=%0b exp=0", bus.stall_if); else n_pass++;
        tick(); idle(); #1;
        n_chk++; if (bus.bubble_id !== 1'b0) $display("FAIL fl_end got=%0b exp=0", bus.bubble_id); else n_pass++;
        tick(); bus.flow_change = 1'b1;
        tick(); bus.flow_change = 1'b1;
        tick(); bus.flow_change = 1'b0; #1;
        n_chk++; if (bus.bubble_id !== 1'b1) $display("FAIL fl_reload got=%0b exp=1", bus.bubble_id); else n_pass++;
        tick(); #1;
        n_chk++; if (bus.bubble_id !== 1'b0) $display("FAIL fl_reload_end got=%0b exp=0", bus.bubble_id); else n_pass++;
        tick();
    endtask

    task automatic test_halt();
        tick(); drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL hlt_accept_stall got=%0b exp=0", bus.stall_if); else n_pass++;
        tick(); drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); #1;
        n_chk++; if (bus.stall_if !== 1'b1) $display("FAIL hlt_stall got=%0b exp=1", bus.stall_if); else n_pass++;
        n_chk++; if (bus.bubble_id !== 1'b1) $display("FAIL hlt_bubble got=%0b exp=1", bus.bubble_id); else n_pass++;
        n_chk++; if (bus.hlt_done !== 1'b0) $display("FAIL hlt_done_p0 got=%0b exp=0", bus.hlt_done); else n_pass++;
        tick(); #1;
        n_chk++; if (bus.hlt_done !== 1'b0) $display("FAIL hlt_done_p1 got=%0b exp=0", bus.hlt_done); else n_pass++;
        tick(); #1;
        n_chk++; if (bus.hlt_done !== 1'b1) $display("FAIL hlt_done_p2 got=%0b exp=1", bus.hlt_done); else n_pass++;
        tick(); tick(); #1;
        n_chk++; if (bus.hlt_done !== 1'b1) $display("FAIL hlt_sticky got=%0b exp=1", bus.hlt_done); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b1) $display("FAIL hlt_stall_hold got=%0b exp=1", bus.stall_if); else n_pass++;
        rst = 1'b1; idle();
        tick(); rst = 1'b0; #1;
        n_chk++; if (bus.hlt_done !== 1'b0) $display("FAIL hlt_rst_clear got=%0b exp=0", bus.hlt_done); else n_pass++;
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); bus.flow_change = 1'b1;
        tick(); idle();
        for (int i = 0; i < 4; i++) tick();
        #1;
        n_chk++; if (bus.hlt_done !== 1'b0) $display("FAIL hlt_squashed got=%0b exp=0", bus.hlt_done); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL hlt_squash_stall got=%0b exp=0", bus.stall_if); else n_pass++;
    endtask

    task automatic test_reset_mul();
        tick(); drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
        tick(); drive(1, 10, 1, 0, 0, 11, 1, 0, 1, 0);
        tick(); idle(); #1;
        n_chk++; if (bus.mul_busy !== 1'b1) $display("FAIL rm_busy got=%0b exp=1", bus.mul_busy); else n_pass++;
        n_chk++; if (bus.byp_sel !== 4'b0001) $display("FAIL rm_byp got=%b exp=0001", bus.byp_sel); else n_pass++;
        rst = 1'b1; #1;
        n_chk++; if (bus.mul_busy !== 1'b0) $display("FAIL rm_busy_in_rst got=%0b exp=0", bus.mul_busy); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL rm_stall_in_rst got=%0b exp=0", bus.stall_if); else n_pass++;
        tick(); rst = 1'b0; #1;
        n_chk++; if (bus.mul_busy !== 1'b0) $display("FAIL rm_busy_after got=%0b exp=0", bus.mul_busy); else n_pass++;
        n_chk++; if (bus.stall_if !== 1'b0) $display("FAIL rm_stall_after got=%0b exp=0", bus.stall_if); else n_pass++;
        n_chk++; if (bus.byp_sel !== 4'b0000) $display("FAIL rm_byp_after got=%b exp=0000", bus.byp_sel); else n_pass++;
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_mul();
        test_flush();
        test_halt();
        test_reset_mul();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
